// File: rtl/result_checker_if.sv
// Expected-value push and observed-sample strobe bundle for result_checker.
interface result_checker_if #(
  parameter int WIDTH = 8
);
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_ready;
  logic             obs_valid;
  logic [WIDTH-1:0] obs_data;

  modport master (output exp_valid, exp_data, obs_valid, obs_data, input exp_ready);
  modport slave  (input exp_valid, exp_data, obs_valid, obs_data, output exp_ready);
endinterface

// File: rtl/result_checker.sv
// In-order response checker: expected values queue in a FIFO and each observed
// sample is compared against the head, with counts, first-fail capture and a verdict.
module result_checker #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  result_checker_if.slave    bus,
  input  logic               start,
  input  logic               finish,
  output logic [1:0]         state,
  output logic [7:0]         pass_count,
  output logic [7:0]         fail_count,
  output logic [7:0]         first_fail_index,
  output logic [WIDTH-1:0]   first_fail_exp,
  output logic [WIDTH-1:0]   first_fail_obs,
  output logic [7:0]         missing,
  output logic               underflow,
  output logic               error,
  output logic               done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [7:0]  TO_C     = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ, occ_nxt;
  logic [7:0]       idle_q, idle_nxt;
  logic             full, empty, push, pop, cmp_en, uflow, match;
  logic             drain_exit, clear_run;
  logic [WIDTH-1:0] head;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Index is taken at 9 bits so that pass+fail beyond 255 clamps instead of wrapping.
  function automatic logic [7:0] sat_idx(input logic [7:0] p, input logic [7:0] f);
    logic [8:0] s;
    s = {1'b0, p} + {1'b0, f};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign full          = (occ == FULL_OCC);
  assign empty         = (occ == '0);
  assign bus.exp_ready = !full && (state_q == S_IDLE || state_q == S_RUN);
  assign push          = bus.exp_valid && bus.exp_ready;
  assign cmp_en        = bus.obs_valid && (state_q == S_RUN || state_q == S_DRAIN);
  assign pop           = cmp_en && !empty;
  assign uflow         = cmp_en && empty;
  assign head          = mem[rd_ptr];
  assign match         = (head == bus.obs_data);
  assign occ_nxt       = occ + (AW+1)'(push) - (AW+1)'(pop);
  assign idle_nxt      = bus.obs_valid ? 8'd0 : idle_q + 8'd1;
  assign clear_run     = (state_q == S_DONE) && start;
  assign state         = state_q;

  always_comb begin
    state_d    = state_q;
    drain_exit = 1'b0;
    case (state_q)
      S_IDLE:  if (start)  state_d = S_RUN;
      S_RUN:   if (finish) state_d = S_DRAIN;
      S_DRAIN: if (occ_nxt == '0 || idle_nxt == TO_C) begin
                 state_d    = S_DONE;
                 drain_exit = 1'b1;
               end
      S_DONE:  if (start)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; only pointers and occupancy define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.exp_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_run) begin
      state_q          <= reset ? S_IDLE : state_d;
      done             <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      idle_q           <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_index <= '0;
      first_fail_exp   <= '0;
      first_fail_obs   <= '0;
      missing          <= '0;
      underflow        <= 1'b0;
      error            <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == S_DONE);
      occ     <= occ_nxt;
      idle_q  <= (state_q == S_DRAIN) ? idle_nxt : 8'd0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (pop) begin
        if (match) begin
          pass_count <= sat_inc(pass_count);
        end else begin
          fail_count <= sat_inc(fail_count);
          error      <= 1'b1;
          // fail_count saturates and never returns to zero within a run.
          if (fail_count == 8'd0) begin
            first_fail_index <= sat_idx(pass_count, fail_count);
            first_fail_exp   <= head;
            first_fail_obs   <= bus.obs_data;
          end
        end
      end
      if (uflow) begin
        underflow <= 1'b1;
        error     <= 1'b1;
      end
      if (drain_exit) begin
        missing <= 8'(occ_nxt);
        if (occ_nxt != '0) error <= 1'b1;
      end
    end
  end
endmodule

// File: doc/result_checker.md
# result_checker

Self-checking response monitor for the 8-bit processor bench flow: the receiving end of a stimulus stream. The stimulus source pushes expected result bytes into an internal FIFO. Observed DUT outputs, such as ALU out, register-file writeData or data-memory data_out, arrive on a sample strobe. Each sample is compared in order against the FIFO head, and the block accumulates pass/fail counts, captures the first mismatch and reports a final verdict after a drain phase.

## Interface
- WIDTH, 8, data width of expected and observed values
- DEPTH, 8, expected-value FIFO entries (power of two, 2..64)
- TIMEOUT, 16, idle cycles allowed in DRAIN before forcing DONE (1..255)
- clk  in  1  rising-edge clock; one clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- exp_valid  in  1  push expected value
- exp_data  in  WIDTH  expected value
- exp_ready  out  1  push accepted this cycle when high
- obs_valid  in  1  observed sample strobe
- obs_data  in  WIDTH  observed value
- start  in  1  begin or restart a check run
- finish  in  1  stimulus complete; enter drain
- state  out  2  00 IDLE, 01 RUN, 10 DRAIN, 11 DONE
- pass_count  out  8  matching compares, saturating at 255
- fail_count  out  8  mismatching compares, saturating at 255
- first_fail_index  out  8  compare index (0-based) of first mismatch
- first_fail_exp  out  WIDTH  expected value at first mismatch
- first_fail_obs  out  WIDTH  observed value at first mismatch
- missing  out  8  FIFO occupancy left at DRAIN exit
- underflow  out  1  sticky: obs_valid with empty FIFO
- error  out  1  sticky verdict: any fail, underflow or missing>0
- done  out  1  high while state==DONE

## Operation
- Reset sets state IDLE, FIFO empty, and all counters, captures, missing, underflow, error and done to 0. Reset dominates every other input, including mid-run.
- exp_ready = !full && state is IDLE or RUN. A push happens when exp_valid && exp_ready. A push while full, or while in DRAIN or DONE, is dropped silently.
- IDLE: pushes are accepted and obs_valid is ignored. start → RUN. finish is ignored.
- RUN: when obs_valid and the FIFO is not empty, pop the head, compare it with obs_data, and increment pass_count or fail_count.
  - On the first mismatch of the run, capture index, expected and observed values, and set error.
  - When obs_valid and the FIFO is empty, set underflow and error; counters and index are unchanged.
  - finish → DRAIN. If start and finish are high together, finish wins.
- Compare index = pass_count + fail_count before the update, computed at full 9-bit width and saturated at 255.
- DRAIN: compares continue as in RUN; pushes are blocked. An idle counter clears on each obs_valid and increments otherwise.
  - Exit to DONE when the FIFO is empty or the idle counter reaches TIMEOUT.
  - At exit, missing = occupancy; if missing>0, set error.
- DONE: all outputs hold and obs_valid is ignored. start → IDLE with FIFO, counters, captures, missing, underflow and error cleared; a push in that same cycle is dropped.
- Same-cycle push and pop: both take effect and occupancy is unchanged.
  - When full, the push is dropped because exp_ready is low.
  - When empty, the pop sees empty, so underflow is set and the pushed value is stored. There is no bypass.
- FIFO pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.

## Timing
- Every output is registered except exp_ready, which is combinational from full and state.
- Compare latency: obs_valid in cycle N → counts, captures and error valid after edge N+1.
- start in IDLE → state=RUN after the next edge. A sample with obs_valid in that same cycle is ignored.
- DRAIN exit is evaluated each cycle, after that cycle's pop. With FIFO empty on entry, DONE follows one cycle after DRAIN. TIMEOUT=k means k consecutive idle cycles in DRAIN.
- done asserts the cycle state becomes DONE.

## Test plan
- Basic match: push 0x79, 0x25, 0xA9; start; observe 0x79, 0x25, 0xA9; finish → pass_count=3, fail_count=0, missing=0, error=0, done=1.
- Mismatch capture: push 0x11, 0x22, 0x33; observe 0x11, 0x20, 0x30 → fail_count=2, pass_count=1, first_fail_index=1, first_fail_exp=0x22, first_fail_obs=0x20, error=1.
- Full and underflow: push DEPTH+2 values → exp_ready low after DEPTH pushes, last 2 dropped. Observe DEPTH+1 samples → underflow=1, pass+fail=DEPTH.
- Drain timeout: push 4, observe 1, finish, no further obs → DONE exactly TIMEOUT cycles after DRAIN entry, missing=3, error=1.
- Simultaneous push/pop on an empty FIFO in RUN → underflow=1, occupancy=1. The next obs matching the pushed value → pass_count=1.
- Reset mid-DRAIN: reset asserted → next edge gives state=IDLE, all counters 0, error=0, exp_ready=1. start in DONE → IDLE with all results cleared.
